// File: rtl/key_debounce_ctrl.sv
// Four independent debouncers for active-low board keys: debounced level per key
// plus registered press, release and long-press pulses.
module key_debounce_ctrl #(
  parameter logic [26:0] DEBOUNCE_CYCLES = 27'd1_000_000,
  parameter logic [26:0] LONG_CYCLES     = 27'd50_000_000
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic [3:0] KEY,
  output logic [3:0] KEY_STATE,
  output logic [3:0] KEY_PRESS,
  output logic [3:0] KEY_RELEASE,
  output logic [3:0] KEY_LONG
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } key_state_t;

  localparam logic [26:0] DB_LAST   = DEBOUNCE_CYCLES - 27'd1;
  localparam logic [26:0] LONG_LAST = LONG_CYCLES - 27'd1;

  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] ks;

  // Synchronizer flops reset to 1 so every key reads as released.
  // NOTE: sequential state uses non-blocking assignments so each flop samples pre-edge values.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  assign ks = ~sync2;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_state_t  state_q, state_d;
    logic [26:0] dcnt_q, dcnt_d;
    logic [26:0] hcnt_q, hcnt_d;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        long_q, long_d;

    // NOTE: async reset clears counters and pulse flops too, so an abort never emits a stale pulse.
    always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
        state_q   <= IDLE;
        dcnt_q    <= '0;
        hcnt_q    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        dcnt_q    <= dcnt_d;
        hcnt_q    <= hcnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
      end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      hcnt_d    = hcnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ks[i]) begin
            state_d = PRESS_DB;
            dcnt_d  = '0;
          end
        end
        PRESS_DB: begin
          if (!ks[i]) begin
            state_d = IDLE;
            dcnt_d  = '0;
          end else if (dcnt_q == DB_LAST) begin
            state_d = HELD;
            dcnt_d  = '0;
            hcnt_d  = '0;
            press_d = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 27'd1;
          end
        end
        HELD: begin
          if (!ks[i]) begin
            state_d = REL_DB;
            dcnt_d  = '0;
          end else if (hcnt_q != LONG_CYCLES) begin
            // Saturation at LONG_CYCLES guarantees a single long pulse per press.
            hcnt_d = hcnt_q + 27'd1;
            long_d = (hcnt_q == LONG_LAST);
          end
        end
        REL_DB: begin
          // hcnt is left untouched here so a bounce resumes the hold count.
          if (ks[i]) begin
            state_d = HELD;
          end else if (dcnt_q == DB_LAST) begin
            state_d   = IDLE;
            dcnt_d    = '0;
            release_d = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 27'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign KEY_STATE[i]   = (state_q == HELD) || (state_q == REL_DB);
    assign KEY_PRESS[i]   = press_q;
    assign KEY_RELEASE[i] = release_q;
    assign KEY_LONG[i]    = long_q;
  end

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Bench for key_debounce_ctrl with DEBOUNCE_CYCLES=8, LONG_CYCLES=32: directed
// scenarios plus random key activity, all checked against a run-length reference model.
module tb_key_debounce_ctrl;

  localparam int DBI = 8;
  localparam int LGI = 32;

  logic       CLK_50M = 1'b0;
  logic       RST;
  logic [3:0] KEY;
  logic [3:0] KEY_STATE;
  logic [3:0] KEY_PRESS;
  logic [3:0] KEY_RELEASE;
  logic [3:0] KEY_LONG;

  int n_cmp = 0;
  int n_mis = 0;

  key_debounce_ctrl #(
    .DEBOUNCE_CYCLES(27'd8),
    .LONG_CYCLES    (27'd32)
  ) dut (
    .CLK_50M    (CLK_50M),
    .RST        (RST),
    .KEY        (KEY),
    .KEY_STATE  (KEY_STATE),
    .KEY_PRESS  (KEY_PRESS),
    .KEY_RELEASE(KEY_RELEASE),
    .KEY_LONG   (KEY_LONG)
  );

  always #10 CLK_50M = ~CLK_50M;

  // Reference model: a key's accepted level flips once the sampled level has
  // disagreed with it for DEBOUNCE+1 consecutive samples; hold time accrues only
  // on pressed samples while no release run is pending.
  logic [3:0] m_d1, m_d2;
  bit         m_acc  [4];
  int         m_run  [4];
  int         m_hold [4];
  logic [3:0] m_press, m_rel, m_long;

  task automatic model_reset();
    m_d1 = 4'hF;
    m_d2 = 4'hF;
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    for (int k = 0; k < 4; k++) begin
      m_acc[k]  = 1'b0;
      m_run[k]  = 0;
      m_hold[k] = 0;
    end
  endtask

  task automatic model_edge(input logic [3:0] raw);
    logic [3:0] smp;
    smp     = ~m_d2;
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    for (int k = 0; k < 4; k++) begin
      if (m_acc[k] && smp[k] && m_run[k] == 0) begin
        if (m_hold[k] == LGI - 1) m_long[k] = 1'b1;
        if (m_hold[k] < LGI) m_hold[k]++;
      end
      if (smp[k] != m_acc[k]) begin
        m_run[k]++;
        if (m_run[k] == DBI + 1) begin
          m_acc[k] = ~m_acc[k];
          m_run[k] = 0;
          if (m_acc[k]) begin
            m_press[k] = 1'b1;
            m_hold[k]  = 0;
          end else begin
            m_rel[k] = 1'b1;
          end
        end
      end else begin
        m_run[k] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = raw;
  endtask

  function automatic logic [3:0] m_state();
    logic [3:0] s;
    for (int k = 0; k < 4; k++) s[k] = m_acc[k];
    return s;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {KEY_STATE, KEY_PRESS, KEY_RELEASE, KEY_LONG}, 16'h0000);
  endtask

  // One clock edge: advance the model with the KEY value present at the edge,
  // then compare every output 1 time unit later.
  task automatic step();
    @(posedge CLK_50M);
    if (RST) model_reset();
    else     model_edge(KEY);
    #1;
    check("state",   {12'h000, KEY_STATE},   {12'h000, m_state()});
    check("press",   {12'h000, KEY_PRESS},   {12'h000, m_press});
    check("release", {12'h000, KEY_RELEASE}, {12'h000, m_rel});
    check("long",    {12'h000, KEY_LONG},    {12'h000, m_long});
    check("exclusive",
          {12'h000, (KEY_PRESS & KEY_RELEASE) | (KEY_PRESS & KEY_LONG) | (KEY_RELEASE & KEY_LONG)},
          16'h0000);
  endtask

  int         press_at, rel_at, long_at;
  int         np, nr, nl, npulse, st_bad;
  logic [3:0] pv, rv, st_or;
  int         dur [4];

  initial begin
    RST = 1'b1;
    KEY = 4'hF;
    model_reset();
    #1;
    check_all_zero("reset_async");
    repeat (3) step();
    check_all_zero("reset_held");
    RST = 1'b0;
    repeat (4) step();

    // Single press on key 0, then release.
    KEY[0] = 1'b0;
    press_at = -1; np = 0; pv = '0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (KEY_PRESS != 4'h0) begin np++; press_at = i; pv = KEY_PRESS; end
    end
    check_int("k0_press_edge", press_at, 10);
    check_int("k0_press_count", np, 1);
    check("k0_press_vec", {12'h000, pv}, 16'h0001);
    check("k0_state_held", {12'h000, KEY_STATE}, 16'h0001);
    KEY[0] = 1'b1;
    rel_at = -1; nr = 0; rv = '0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (KEY_RELEASE != 4'h0) begin nr++; rel_at = i; rv = KEY_RELEASE; end
    end
    check_int("k0_release_edge", rel_at, 10);
    check_int("k0_release_count", nr, 1);
    check("k0_release_vec", {12'h000, rv}, 16'h0001);
    check("k0_state_idle", {12'h000, KEY_STATE}, 16'h0000);

    // Short bounces on key 1 must never be accepted.
    npulse = 0; st_or = '0;
    repeat (3) begin
      KEY[1] = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step();
        if ((KEY_PRESS | KEY_RELEASE | KEY_LONG) != 4'h0) npulse++;
        st_or |= KEY_STATE;
      end
      KEY[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
        step();
        if ((KEY_PRESS | KEY_RELEASE | KEY_LONG) != 4'h0) npulse++;
        st_or |= KEY_STATE;
      end
    end
    check_int("bounce_pulses", npulse, 0);
    check("bounce_state", {12'h000, st_or}, 16'h0000);
    repeat (10) step();

    // Long hold on key 2.
    KEY[2] = 1'b0;
    press_at = -1; long_at = -1; np = 0; nl = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (KEY_PRESS[2]) begin np++; press_at = i; end
      if (KEY_LONG[2])  begin nl++; long_at = i; end
    end
    check_int("k2_press_edge", press_at, 10);
    check_int("k2_press_count", np, 1);
    check_int("k2_long_count", nl, 1);
    check_int("k2_long_delay", long_at - press_at, 32);
    KEY[2] = 1'b1;
    rel_at = -1; nr = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (KEY_RELEASE[2]) begin nr++; rel_at = i; end
    end
    check_int("k2_release_edge", rel_at, 10);
    check_int("k2_release_count", nr, 1);

    // Keys 0 and 3 together.
    KEY = 4'b0110;
    pv = '0; press_at = -1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (KEY_PRESS != 4'h0) begin pv = KEY_PRESS; press_at = i; end
    end
    check("k03_press_vec", {12'h000, pv}, 16'h0009);
    check_int("k03_press_edge", press_at, 10);
    KEY = 4'hF;
    rv = '0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (KEY_RELEASE != 4'h0) rv = KEY_RELEASE;
    end
    check("k03_release_vec", {12'h000, rv}, 16'h0009);

    // Reset during a held key 1, then re-debounce after reset release.
    KEY[1] = 1'b0;
    press_at = -1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (KEY_PRESS[1]) press_at = i;
    end
    check_int("k1_press_edge", press_at, 10);
    RST = 1'b1;
    model_reset();
    #1;
    check_all_zero("k1_reset_async");
    repeat (3) step();
    check_all_zero("k1_reset_held");
    RST = 1'b0;
    press_at = -1; np = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (KEY_PRESS[1]) begin np++; press_at = i; end
    end
    check_int("k1_repress_edge", press_at, 10);
    check_int("k1_repress_count", np, 1);
    KEY[1] = 1'b1;
    repeat (15) step();

    // Three-cycle glitch while key 0 is held: hold count resumes, no release.
    press_at = -1; long_at = -1; nr = 0; st_bad = 0;
    for (int i = 0; i < 60; i++) begin
      KEY[0] = (i >= 14 && i < 17);
      step();
      if (KEY_PRESS[0])   press_at = i;
      if (KEY_LONG[0])    long_at = i;
      if (KEY_RELEASE[0]) nr++;
      if (i >= 10 && !KEY_STATE[0]) st_bad++;
    end
    check_int("glitch_press_edge", press_at, 10);
    check_int("glitch_release_count", nr, 0);
    check_int("glitch_state_drop", st_bad, 0);
    check_int("glitch_long_edge", long_at, 46);
    KEY[0] = 1'b1;
    repeat (15) step();

    // Reset mid-debounce on key 3 aborts without any pulse.
    KEY[3] = 1'b0;
    repeat (6) step();
    RST = 1'b1;
    model_reset();
    #1;
    check_all_zero("k3_reset_async");
    step();
    RST = 1'b0;
    KEY[3] = 1'b1;
    npulse = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if ((KEY_PRESS | KEY_RELEASE | KEY_LONG) != 4'h0) npulse++;
    end
    check_int("k3_abort_pulses", npulse, 0);

    // Random key activity with occasional resets, checked cycle by cycle.
    for (int k = 0; k < 4; k++) dur[k] = $urandom_range(1, 20);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) begin
        dur[k]--;
        if (dur[k] <= 0) begin
          KEY[k] = ~KEY[k];
          if ($urandom_range(0, 3) == 0) dur[k] = $urandom_range(20, 70);
          else                           dur[k] = $urandom_range(1, 12);
        end
      end
      if (RST) begin
        RST = 1'b0;
      end else if ($urandom_range(0, 499) == 0) begin
        RST = 1'b1;
        model_reset();
        #1;
        check_all_zero("rand_reset_async");
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
